// File: rtl/hazard_scoreboard.sv
// Pipeline hazard scoreboard: a shadow copy of X..writeback that decides stalls,
// bubbles and flushes for the instruction in D and selects X operand forwarding.
module hazard_scoreboard #(
    parameter int DEPTH      = 3,
    parameter int LOAD_STAGE = 2,
    parameter int FWD_EN     = 1,
    parameter int CNT_W      = 16,
    localparam int FW        = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             d_valid,
    input  logic [4:0]       d_rs1,
    input  logic [4:0]       d_rs2,
    input  logic             d_use1,
    input  logic             d_use2,
    input  logic [4:0]       d_rd,
    input  logic             d_wen,
    input  logic             d_load,
    input  logic             x_redirect,
    input  logic             mem_stall,
    output logic             stall,
    output logic             bubble_x,
    output logic             flush,
    output logic [FW-1:0]    fwd_a,
    output logic [FW-1:0]    fwd_b,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    typedef struct packed {
        logic       valid;
        logic [4:0] rd;
        logic       wen;
        logic       load;
        logic [4:0] rs1;
        logic [4:0] rs2;
        logic       use1;
        logic       use2;
    } entry_t;

    typedef entry_t [DEPTH-1:0] pipe_t;

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    pipe_t            pipe_q, pipe_d;
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
    logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;
    logic [FW-1:0]    fwd_a_q, fwd_a_d;
    logic [FW-1:0]    fwd_b_q, fwd_b_d;
    logic             hazard_s;
    logic             act_s;
    logic             stall_s;
    logic             bubble_s;
    logic             flush_s;

    function automatic logic prod_match(input entry_t e, input logic [4:0] src, input logic use_b);
        return e.valid && e.wen && (e.rd != 5'd0) && (e.rd == src) && use_b;
    endfunction

    // Scan oldest to youngest so the youngest qualifying producer wins.
    function automatic logic [FW-1:0] fwd_pick(input pipe_t p, input logic [4:0] src, input logic use_b);
        logic [FW-1:0] sel;
        sel = '0;
        if ((FWD_EN != 0) && p[0].valid && use_b && (src != 5'd0)) begin
            for (int s = DEPTH - 1; s >= 1; s--) begin
                if (prod_match(p[s], src, 1'b1) && (!p[s].load || (s >= LOAD_STAGE))) begin
                    sel = FW'(s);
                end else begin
                    sel = sel;
                end
            end
        end else begin
            sel = '0;
        end
        return sel;
    endfunction

    // Hazard detection against every non-retiring stage.
    always_comb begin
        hazard_s = 1'b0;
        for (int s = 0; s < DEPTH - 1; s++) begin
            if (prod_match(pipe_q[s], d_rs1, d_use1) || prod_match(pipe_q[s], d_rs2, d_use2)) begin
                if (FWD_EN == 0) begin
                    hazard_s = 1'b1;
                end else if (pipe_q[s].load && ((s + 1) < LOAD_STAGE)) begin
                    hazard_s = 1'b1;
                end else begin
                    hazard_s = hazard_s;
                end
            end else begin
                hazard_s = hazard_s;
            end
        end
    end

    // Control outputs; gated by rst_n so they read zero during reset.
    always_comb begin
        act_s    = d_valid & hazard_s & ~x_redirect;
        stall_s  = rst_n & (mem_stall | act_s);
        bubble_s = rst_n & act_s & ~mem_stall;
        flush_s  = rst_n & x_redirect & ~mem_stall;
    end

    // Shadow pipeline advance, saturating counters and next forwarding selects.
    always_comb begin
        pipe_d = pipe_q;
        if (!mem_stall) begin
            for (int s = DEPTH - 1; s >= 1; s--) begin
                pipe_d[s] = pipe_q[s-1];
            end
            pipe_d[0].valid = d_valid & ~bubble_s & ~flush_s;
            pipe_d[0].rd    = d_rd;
            pipe_d[0].wen   = d_wen;
            pipe_d[0].load  = d_load;
            pipe_d[0].rs1   = d_rs1;
            pipe_d[0].rs2   = d_rs2;
            pipe_d[0].use1  = d_use1;
            pipe_d[0].use2  = d_use2;
        end else begin
            pipe_d = pipe_q;
        end

        if (stall_s && (stall_cnt_q != CNT_MAX)) begin
            stall_cnt_d = stall_cnt_q + CNT_W'(1);
        end else begin
            stall_cnt_d = stall_cnt_q;
        end

        if (flush_s && (flush_cnt_q != CNT_MAX)) begin
            flush_cnt_d = flush_cnt_q + CNT_W'(1);
        end else begin
            flush_cnt_d = flush_cnt_q;
        end

        fwd_a_d = fwd_pick(pipe_d, pipe_d[0].rs1, pipe_d[0].use1);
        fwd_b_d = fwd_pick(pipe_d, pipe_d[0].rs2, pipe_d[0].use2);
    end

    // State registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pipe_q      <= '0;
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
            fwd_a_q     <= '0;
            fwd_b_q     <= '0;
        end else begin
            pipe_q      <= pipe_d;
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
            fwd_a_q     <= fwd_a_d;
            fwd_b_q     <= fwd_b_d;
        end
    end

    assign stall     = stall_s;
    assign bubble_x  = bubble_s;
    assign flush     = flush_s;
    assign fwd_a     = fwd_a_q;
    assign fwd_b     = fwd_b_q;
    assign stall_cnt = stall_cnt_q;
    assign flush_cnt = flush_cnt_q;

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Directed bench for hazard_scoreboard: default, stall-only and 4-bit-counter
// instances share one stimulus stream.
module tb_hazard_scoreboard;

    logic       clk;
    logic       rst_n;
    logic       d_valid;
    logic [4:0] d_rs1, d_rs2, d_rd;
    logic       d_use1, d_use2, d_wen, d_load;
    logic       x_redirect, mem_stall;

    logic        stall, bubble_x, flush;
    logic [1:0]  fwd_a, fwd_b;
    logic [15:0] stall_cnt, flush_cnt;

    logic        n_stall, n_bubble, n_flush;
    logic [1:0]  n_fwd_a, n_fwd_b;
    logic [15:0] n_stall_cnt, n_flush_cnt;

    logic        s_stall, s_bubble, s_flush;
    logic [1:0]  s_fwd_a, s_fwd_b;
    logic [3:0]  s_stall_cnt, s_flush_cnt;

    int checks   = 0;
    int failures = 0;

    hazard_scoreboard #(.DEPTH(3), .LOAD_STAGE(2), .FWD_EN(1), .CNT_W(16)) dut (
        .clk(clk), .rst_n(rst_n), .d_valid(d_valid), .d_rs1(d_rs1), .d_rs2(d_rs2),
        .d_use1(d_use1), .d_use2(d_use2), .d_rd(d_rd), .d_wen(d_wen), .d_load(d_load),
        .x_redirect(x_redirect), .mem_stall(mem_stall), .stall(stall), .bubble_x(bubble_x),
        .flush(flush), .fwd_a(fwd_a), .fwd_b(fwd_b), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt));

    hazard_scoreboard #(.DEPTH(3), .LOAD_STAGE(2), .FWD_EN(0), .CNT_W(16)) dut_nf (
        .clk(clk), .rst_n(rst_n), .d_valid(d_valid), .d_rs1(d_rs1), .d_rs2(d_rs2),
        .d_use1(d_use1), .d_use2(d_use2), .d_rd(d_rd), .d_wen(d_wen), .d_load(d_load),
        .x_redirect(x_redirect), .mem_stall(mem_stall), .stall(n_stall), .bubble_x(n_bubble),
        .flush(n_flush), .fwd_a(n_fwd_a), .fwd_b(n_fwd_b), .stall_cnt(n_stall_cnt), .flush_cnt(n_flush_cnt));

    hazard_scoreboard #(.DEPTH(3), .LOAD_STAGE(2), .FWD_EN(1), .CNT_W(4)) dut_sat (
        .clk(clk), .rst_n(rst_n), .d_valid(d_valid), .d_rs1(d_rs1), .d_rs2(d_rs2),
        .d_use1(d_use1), .d_use2(d_use2), .d_rd(d_rd), .d_wen(d_wen), .d_load(d_load),
        .x_redirect(x_redirect), .mem_stall(mem_stall), .stall(s_stall), .bubble_x(s_bubble),
        .flush(s_flush), .fwd_a(s_fwd_a), .fwd_b(s_fwd_b), .stall_cnt(s_stall_cnt), .flush_cnt(s_flush_cnt));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        d_valid = 1'b0; d_rs1 = 5'd0; d_rs2 = 5'd0; d_use1 = 1'b0; d_use2 = 1'b0;
        d_rd = 5'd0; d_wen = 1'b0; d_load = 1'b0;
    endtask

    task automatic issue(input logic [4:0] rs1, input logic u1, input logic [4:0] rs2,
                         input logic u2, input logic [4:0] rd, input logic wen, input logic ld);
        d_valid = 1'b1; d_rs1 = rs1; d_use1 = u1; d_rs2 = rs2; d_use2 = u2;
        d_rd = rd; d_wen = wen; d_load = ld;
    endtask

    task automatic drain();
        idle(); x_redirect = 1'b0; mem_stall = 1'b0;
        repeat (3) tick();
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        issue(5'd5, 1'b1, 5'd6, 1'b1, 5'd7, 1'b1, 1'b0);
        mem_stall = 1'b1; x_redirect = 1'b1;
        #7;
        checks++; if (stall !== 1'b0) begin failures++; $display("FAIL rst_stall act=%0b req=0", stall); end
        checks++; if (bubble_x !== 1'b0) begin failures++; $display("FAIL rst_bubble act=%0b req=0", bubble_x); end
        checks++; if (flush !== 1'b0) begin failures++; $display("FAIL rst_flush act=%0b req=0", flush); end
        checks++; if (fwd_a !== 2'd0 || fwd_b !== 2'd0) begin failures++; $display("FAIL rst_fwd act=%0d/%0d req=0/0", fwd_a, fwd_b); end
        checks++; if (stall_cnt !== 16'd0 || flush_cnt !== 16'd0) begin failures++; $display("FAIL rst_cnt act=%0d/%0d req=0/0", stall_cnt, flush_cnt); end
        tick();
        checks++; if (stall_cnt !== 16'd0) begin failures++; $display("FAIL rst_cnt_edge act=%0d req=0", stall_cnt); end
        idle(); mem_stall = 1'b0; x_redirect = 1'b0;
        rst_n = 1'b1;
        #1;
        checks++; if (stall !== 1'b0 || flush !== 1'b0) begin failures++; $display("FAIL rel_ctrl act=%0b%0b req=00", stall, flush); end
        tick();
    endtask

    task automatic test_load_use();
        drain();
        issue(5'd0, 1'b0, 5'd0, 1'b0, 5'd5, 1'b1, 1'b1);
        #1;
        checks++; if (stall !== 1'b0) begin failures++; $display("FAIL lu_load_stall act=%0b req=0", stall); end
        tick();
        issue(5'd5, 1'b1, 5'd0, 1'b0, 5'd6, 1'b1, 1'b0);
        #1;
        checks++; if (stall !== 1'b1) begin failures++; $display("FAIL lu_stall act=%0b req=1", stall); end
        checks++; if (bubble_x !== 1'b1) begin failures++; $display("FAIL lu_bubble act=%0b req=1", bubble_x); end
        tick();
        checks++; if (stall !== 1'b0 || bubble_x !== 1'b0) begin failures++; $display("FAIL lu_release act=%0b%0b req=00", stall, bubble_x); end
        checks++; if (fwd_a !== 2'd0) begin failures++; $display("FAIL lu_bubble_fwd act=%0d req=0", fwd_a); end
        tick();
        idle();
        #1;
        checks++; if (fwd_a !== 2'd2) begin failures++; $display("FAIL lu_fwd_a act=%0d req=2", fwd_a); end
        checks++; if (fwd_b !== 2'd0) begin failures++; $display("FAIL lu_fwd_b act=%0d req=0", fwd_b); end
        checks++; if (stall_cnt !== 16'd1) begin failures++; $display("FAIL lu_stall_cnt act=%0d req=1", stall_cnt); end
        // Independent instruction between load and consumer: no stall, forward from stage 2.
        drain();
        issue(5'd0, 1'b0, 5'd0, 1'b0, 5'd5, 1'b1, 1'b1);
        tick();
        issue(5'd0, 1'b0, 5'd0, 1'b0, 5'd9, 1'b1, 1'b0);
        tick();
        issue(5'd5, 1'b1, 5'd0, 1'b0, 5'd6, 1'b1, 1'b0);
        #1;
        checks++; if (stall !== 1'b0) begin failures++; $display("FAIL gap_stall act=%0b req=0", stall); end
        tick();
        idle();
        #1;
        checks++; if (fwd_a !== 2'd2) begin failures++; $display("FAIL gap_fwd_a act=%0d req=2", fwd_a); end
    endtask

    task automatic test_alu_forward();
        drain();
        issue(5'd0, 1'b0, 5'd0, 1'b0, 5'd7, 1'b1, 1'b0);
        tick();
        issue(5'd7, 1'b0, 5'd7, 1'b1, 5'd8, 1'b1, 1'b0);
        #1;
        checks++; if (stall !== 1'b0) begin failures++; $display("FAIL alu_stall act=%0b req=0", stall); end
        tick();
        idle();
        #1;
        checks++; if (fwd_b !== 2'd1) begin failures++; $display("FAIL alu_fwd_b act=%0d req=1", fwd_b); end
        checks++; if (fwd_a !== 2'd0) begin failures++; $display("FAIL alu_fwd_a_nouse act=%0d req=0", fwd_a); end
        checks++; if (stall_cnt !== 16'd1) begin failures++; $display("FAIL alu_stall_cnt act=%0d req=1", stall_cnt); end
        drain();
        issue(5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b1, 1'b0);
        tick();
        issue(5'd0, 1'b0, 5'd0, 1'b1, 5'd8, 1'b1, 1'b0);
        tick();
        idle();
        #1;
        checks++; if (fwd_b !== 2'd0) begin failures++; $display("FAIL x0_fwd_b act=%0d req=0", fwd_b); end
    endtask

    task automatic test_youngest();
        drain();
        issue(5'd0, 1'b0, 5'd0, 1'b0, 5'd9, 1'b1, 1'b0);
        tick();
        issue(5'd0, 1'b0, 5'd0, 1'b0, 5'd9, 1'b1, 1'b0);
        tick();
        issue(5'd9, 1'b1, 5'd9, 1'b1, 5'd10, 1'b1, 1'b0);
        tick();
        idle();
        #1;
        checks++; if (fwd_a !== 2'd1 || fwd_b !== 2'd1) begin failures++; $display("FAIL young_fwd act=%0d/%0d req=1/1", fwd_a, fwd_b); end
    endtask

    task automatic test_redirect();
        drain();
        issue(5'd0, 1'b0, 5'd0, 1'b0, 5'd7, 1'b1, 1'b0);
        tick();
        issue(5'd0, 1'b0, 5'd0, 1'b0, 5'd5, 1'b1, 1'b1);
        tick();
        issue(5'd5, 1'b1, 5'd7, 1'b1, 5'd6, 1'b1, 1'b0);
        x_redirect = 1'b1;
        #1;
        checks++; if (flush !== 1'b1) begin failures++; $display("FAIL rd_flush act=%0b req=1", flush); end
        checks++; if (stall !== 1'b0 || bubble_x !== 1'b0) begin failures++; $display("FAIL rd_no_stall act=%0b%0b req=00", stall, bubble_x); end
        tick();
        idle(); x_redirect = 1'b0;
        #1;
        checks++; if (fwd_a !== 2'd0 || fwd_b !== 2'd0) begin failures++; $display("FAIL rd_squash_fwd act=%0d/%0d req=0/0", fwd_a, fwd_b); end
        checks++; if (flush_cnt !== 16'd1) begin failures++; $display("FAIL rd_flush_cnt act=%0d req=1", flush_cnt); end
        checks++; if (stall_cnt !== 16'd1) begin failures++; $display("FAIL rd_stall_cnt act=%0d req=1", stall_cnt); end
    endtask

    task automatic test_mem_stall();
        drain();
        issue(5'd0, 1'b0, 5'd0, 1'b0, 5'd7, 1'b1, 1'b0);
        tick();
        issue(5'd7, 1'b1, 5'd0, 1'b0, 5'd5, 1'b1, 1'b1);
        tick();
        idle(); mem_stall = 1'b1; x_redirect = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1;
            checks++; if (stall !== 1'b1 || bubble_x !== 1'b0 || flush !== 1'b0) begin failures++; $display("FAIL ms_ctrl%0d act=%0b%0b%0b req=100", i, stall, bubble_x, flush); end
            checks++; if (fwd_a !== 2'd1) begin failures++; $display("FAIL ms_fwd%0d act=%0d req=1", i, fwd_a); end
            tick();
        end
        mem_stall = 1'b0; x_redirect = 1'b0;
        issue(5'd5, 1'b1, 5'd0, 1'b0, 5'd6, 1'b1, 1'b0);
        #1;
        checks++; if (stall !== 1'b1 || bubble_x !== 1'b1) begin failures++; $display("FAIL ms_frozen act=%0b%0b req=11", stall, bubble_x); end
        checks++; if (stall_cnt !== 16'd4) begin failures++; $display("FAIL ms_stall_cnt act=%0d req=4", stall_cnt); end
        tick();
        #1;
        checks++; if (stall !== 1'b0) begin failures++; $display("FAIL ms_resume act=%0b req=0", stall); end
        tick();
        idle();
        #1;
        checks++; if (fwd_a !== 2'd2) begin failures++; $display("FAIL ms_fwd_after act=%0d req=2", fwd_a); end
        checks++; if (stall_cnt !== 16'd5) begin failures++; $display("FAIL ms_stall_cnt2 act=%0d req=5", stall_cnt); end
    endtask

    task automatic test_no_fwd();
        drain();
        issue(5'd0, 1'b0, 5'd0, 1'b0, 5'd3, 1'b1, 1'b0);
        tick();
        issue(5'd3, 1'b1, 5'd3, 1'b1, 5'd4, 1'b1, 1'b0);
        #1;
        checks++; if (n_stall !== 1'b1 || n_bubble !== 1'b1) begin failures++; $display("FAIL nf_stall1 act=%0b%0b req=11", n_stall, n_bubble); end
        checks++; if (stall !== 1'b0) begin failures++; $display("FAIL fw_alu_nostall act=%0b req=0", stall); end
        tick();
        #1;
        checks++; if (n_stall !== 1'b1) begin failures++; $display("FAIL nf_stall2 act=%0b req=1", n_stall); end
        checks++; if (n_fwd_a !== 2'd0 || n_fwd_b !== 2'd0) begin failures++; $display("FAIL nf_fwd_mid act=%0d/%0d req=0/0", n_fwd_a, n_fwd_b); end
        tick();
        #1;
        checks++; if (n_stall !== 1'b0) begin failures++; $display("FAIL nf_stall3 act=%0b req=0", n_stall); end
        tick();
        idle();
        #1;
        checks++; if (n_fwd_a !== 2'd0 || n_fwd_b !== 2'd0) begin failures++; $display("FAIL nf_fwd_x act=%0d/%0d req=0/0", n_fwd_a, n_fwd_b); end
    endtask

    task automatic test_sat_reset();
        drain();
        rst_n = 1'b0;
        #2;
        rst_n = 1'b1;
        issue(5'd0, 1'b0, 5'd0, 1'b0, 5'd5, 1'b1, 1'b1);
        tick();
        issue(5'd5, 1'b1, 5'd0, 1'b0, 5'd6, 1'b1, 1'b0);
        mem_stall = 1'b1;
        repeat (20) tick();
        checks++; if (s_stall_cnt !== 4'd15) begin failures++; $display("FAIL sat_cnt act=%0d req=15", s_stall_cnt); end
        checks++; if (stall_cnt !== 16'd20) begin failures++; $display("FAIL wide_cnt act=%0d req=20", stall_cnt); end
        #2;
        rst_n = 1'b0;
        #1;
        checks++; if (stall !== 1'b0 || bubble_x !== 1'b0 || flush !== 1'b0) begin failures++; $display("FAIL arst_ctrl act=%0b%0b%0b req=000", stall, bubble_x, flush); end
        checks++; if (fwd_a !== 2'd0 || fwd_b !== 2'd0) begin failures++; $display("FAIL arst_fwd act=%0d/%0d req=0/0", fwd_a, fwd_b); end
        checks++; if (stall_cnt !== 16'd0 || s_stall_cnt !== 4'd0) begin failures++; $display("FAIL arst_cnt act=%0d/%0d req=0/0", stall_cnt, s_stall_cnt); end
        mem_stall = 1'b0;
        rst_n = 1'b1;
        #1;
        checks++; if (stall !== 1'b0 || bubble_x !== 1'b0) begin failures++; $display("FAIL arst_hazard_gone act=%0b%0b req=00", stall, bubble_x); end
        tick();
        idle();
        #1;
        checks++; if (fwd_a !== 2'd0 || stall_cnt !== 16'd0) begin failures++; $display("FAIL arst_after act=%0d/%0d req=0/0", fwd_a, stall_cnt); end
    endtask

    initial begin
        idle(); x_redirect = 1'b0; mem_stall = 1'b0; rst_n = 1'b0;
        test_reset();
        test_load_use();
        test_alu_forward();
        test_youngest();
        test_redirect();
        test_mem_stall();
        test_no_fwd();
        test_sat_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/hazard_scoreboard.md
HAZARD_SCOREBOARD -- requirements
Module: hazard_scoreboard

Interface
REQ-001 SHALL have parameter DEPTH, default 3: shadow-pipeline stages from X (stage 0) to last writeback stage (DEPTH-1); legal 2..8.
REQ-002 SHALL have parameter LOAD_STAGE, default 2: first stage at which load data is forwardable; legal 1..DEPTH-1.
REQ-003 SHALL have parameter FWD_EN, default 1: 1 = forwarding enabled, 0 = stall-only mode.
REQ-004 SHALL have parameter CNT_W, default 16: width of the performance counters.
REQ-005 Ports, in order; FW = clog2(DEPTH):
- clk  in  1  sole clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- d_valid  in  1  valid instruction in D.
- d_rs1, d_rs2  in  5 each  D source registers.
- d_use1, d_use2  in  1 each  D instruction reads rs1/rs2.
- d_rd  in  5  D destination register.
- d_wen  in  1  D instruction writes d_rd.
- d_load  in  1  D instruction is a load.
- x_redirect  in  1  X instruction is a taken branch or jump.
- mem_stall  in  1  data memory not ready.
- stall  out  1  hold PC and D register.
- bubble_x  out  1  insert noop into X.
- flush  out  1  squash F and D.
- fwd_a, fwd_b  out  FW each  X operand source; 0 = register file, k = stage k.
- stall_cnt, flush_cnt  out  CNT_W each  performance counters.

Function
REQ-006 SHALL keep a shadow entry {valid, rd, wen, load, rs1, rs2, use1, use2} per stage 0..DEPTH-1.
REQ-007 A producer entry is one with valid=1, wen=1, rd!=0; it matches a source when its rd equals that source and the matching use bit is 1.
REQ-008 Hazard, FWD_EN=1: a matching producer at stage s in 0..DEPTH-2 with load=1 and s+1 < LOAD_STAGE.
REQ-009 Hazard, FWD_EN=0: any matching producer at stage s in 0..DEPTH-2.
REQ-010 stall = mem_stall OR (d_valid AND hazard AND NOT x_redirect); combinational.
REQ-011 bubble_x = d_valid AND hazard AND NOT x_redirect AND NOT mem_stall.
REQ-012 flush = x_redirect AND NOT mem_stall.
REQ-013 mem_stall=1: all entries hold, bubble_x=0, flush=0; the x_redirect source holds x_redirect until mem_stall drops.
REQ-014 Otherwise, each rising edge: entries shift one stage and stage DEPTH-1 retires.
REQ-015 On that shift, stage 0 loads the D fields, with valid forced to 0 when d_valid=0, bubble_x=1, or flush=1.
REQ-016 x_redirect has priority over a hazard in the same cycle: the D instruction is squashed and no bubble is counted.
REQ-017 fwd_a/fwd_b are driven only from registered state: the smallest stage s >= 1 whose producer matches the stage-0 rs1/rs2, with s >= LOAD_STAGE required for loads.
REQ-018 fwd_a/fwd_b = 0 if stage 0 is invalid, FWD_EN=0, the source register is x0, or no stage qualifies.
REQ-019 The youngest match wins; older duplicates are ignored.
REQ-020 Retiring entries are readable from the write-through register file in the same cycle and are never flagged as hazards.
REQ-021 stall_cnt increments on each cycle with stall=1; flush_cnt increments on each cycle with flush=1; both saturate at 2^CNT_W-1 with no wrap.

Reset
REQ-022 rst_n low SHALL asynchronously clear all entry valid bits and both counters.
REQ-023 While rst_n is low, outputs are stall=0, bubble_x=0, flush=0, fwd_a=fwd_b=0.
REQ-024 Release is synchronous-safe: the first edge after rst_n rises behaves as a normal cycle with an empty shadow pipeline.
REQ-025 Reset mid-stall drops all in-flight hazards; no state survives.

Verification (DEPTH=3, LOAD_STAGE=2, FWD_EN=1 unless stated)
REQ-026 Load-use: load x5 issued; next D reads rs1=x5 -> stall=1 and bubble_x=1 for exactly 1 cycle; the consumer enters X with fwd_a=2; stall_cnt=1.
REQ-027 ALU forward: add x7 then sub reading x7 as rs2 -> no stall; fwd_b=1 in the consumer's X cycle; fwd_b=0 for rd=x0 producers.
REQ-028 Redirect vs hazard: x_redirect=1 in the same cycle as a load-use hazard -> flush=1, stall=0, bubble_x=0; next stage 0 invalid; flush_cnt=1.
REQ-029 mem_stall: 3 cycles high with a load in stage 0 -> stall=1 for 3 cycles, entries frozen, fwd_a/fwd_b constant; normal advance resumes afterwards.
REQ-030 FWD_EN=0: ALU producer x3 followed by a consumer of x3 -> stall for DEPTH-1=2 cycles; fwd_a=fwd_b=0 throughout.
REQ-031 Saturation and reset: CNT_W=4 with 20 stall cycles -> stall_cnt=15; rst_n pulsed low mid-stall -> all outputs 0 immediately, without a clock edge.
